// File: rtl/bpred_update_sched.sv
// Purpose : serializes up to NSLOTS resolved branches per cycle from commit onto the single-entry gselect update port.
// Latency : 2 cycles from commit to upd_valid with an empty queue; after that, one update per accepted cycle.
// Backpress: registered cmt_stall when fewer than NSLOTS entries are free; a group that does not fit is dropped whole and sets sticky ovf.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   en                       0 holds issue into the output stage; commits are still accepted
//   flush                    discard queue contents, the output stage and same-cycle commits
//   cmt_br/cmt_takb/cmt_ip   per-slot resolved branch, outcome and address
//   cmt_stall                1 = queue cannot take a full group next cycle
//   upd_valid/upd_ip/upd_takb/upd_ready   update handshake toward the predictor
//   q_count                  queued entries, not counting the output stage
//   ovf                      sticky; a commit group was dropped
// Optional feature: BPSCHED_INIT_EN adds an INIT sweep that seeds all 512 predictor entries weak-taken after reset.
module bpred_update_sched #(
    parameter int AMSB   = 31,
    parameter int NSLOTS = 4,
    parameter int QDEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      flush,
    input  logic [NSLOTS-1:0]         cmt_br,
    input  logic [NSLOTS-1:0]         cmt_takb,
    input  logic [NSLOTS-1:0][AMSB:0] cmt_ip,
    output logic                      cmt_stall,
    output logic                      upd_valid,
    output logic [AMSB:0]             upd_ip,
    output logic                      upd_takb,
    input  logic                      upd_ready,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      ovf
);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam int KW = $clog2(NSLOTS + 1);

    typedef enum logic [1:0] {S_RUN, S_HOLD, S_FLUSH, S_INIT} state_t;

`ifdef BPSCHED_INIT_EN
    localparam state_t RST_STATE = S_INIT;
`else
    localparam state_t RST_STATE = S_RUN;
`endif

    state_t state_q, state_d;

    // Each entry is {takb, ip}.
    logic [AMSB+1:0] mem [QDEPTH];
    logic [PW-1:0]   head, tail;

    logic [NSLOTS-1:0] keep;
    logic [KW-1:0]     off [NSLOTS];
    logic [KW-1:0]     k;
    logic              blocked;
    logic              in_init, flush_eff, pop, push, drop, init_last;
    logic [CW-1:0]     free_cnt, q_count_d;

`ifdef BPSCHED_INIT_EN
    logic [8:0] init_idx;
    assign init_last = upd_valid && upd_ready && (init_idx == 9'h1ff);
`else
    assign init_last = 1'b0;
`endif

    // Keep slots up to and including the first taken branch. off[n] is
    // the slot's position inside the compacted group.
    always_comb begin
        keep    = '0;
        blocked = 1'b0;
        k       = '0;
        for (int n = 0; n < NSLOTS; n++) begin
            off[n]  = k;
            keep[n] = cmt_br[n] & ~blocked;
            if (keep[n]) k = k + KW'(1);
            blocked = blocked | (cmt_br[n] & cmt_takb[n]);
        end
    end

    assign in_init   = (state_q == S_INIT);
    assign flush_eff = flush && !in_init;
    // The output stage takes the head when it is empty or being consumed.
    assign pop       = (state_q == S_RUN) && (q_count != '0) && (!upd_valid || upd_ready);
    // This cycle's pop counts as free room, so a full queue that is draining can still accept.
    assign free_cnt  = CW'(QDEPTH) - q_count + CW'(pop);
    assign push      = !flush_eff && !in_init && (k != '0) && (CW'(k) <= free_cnt);
    assign drop      = !flush_eff && !in_init && (k != '0) && (CW'(k) >  free_cnt);
    assign q_count_d = flush_eff ? '0 : (q_count + (push ? CW'(k) : '0) - CW'(pop));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:   if (flush) state_d = S_FLUSH; else if (!en) state_d = S_HOLD;
            S_HOLD:  if (flush) state_d = S_FLUSH; else if (en)  state_d = S_RUN;
            S_FLUSH: if (flush) state_d = S_FLUSH; else          state_d = S_RUN;
            S_INIT:  if (init_last) state_d = S_RUN;
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= RST_STATE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            for (int n = 0; n < NSLOTS; n++) begin
                if (keep[n]) mem[tail + PW'(off[n])] <= {cmt_takb[n], cmt_ip[n]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head      <= '0;
            tail      <= '0;
            q_count   <= '0;
            upd_valid <= 1'b0;
            upd_ip    <= '0;
            upd_takb  <= 1'b0;
            cmt_stall <= 1'b0;
            ovf       <= 1'b0;
`ifdef BPSCHED_INIT_EN
            init_idx  <= '0;
`endif
        end else begin
            q_count   <= q_count_d;
            cmt_stall <= (state_d == S_INIT) || ((CW'(QDEPTH) - q_count_d) < CW'(NSLOTS));
            if (drop) ovf <= 1'b1;

            if (flush_eff) begin
                head <= tail;
            end else begin
                if (push) tail <= tail + PW'(k);
                if (pop)  head <= head + PW'(1);
            end

            if (in_init) begin
`ifdef BPSCHED_INIT_EN
                // Seed sweep: the index sits in the low address bits.
                if (!upd_valid) begin
                    upd_valid <= 1'b1;
                    upd_ip    <= (AMSB+1)'(init_idx);
                    upd_takb  <= 1'b1;
                end else if (upd_ready) begin
                    if (init_idx == 9'h1ff) begin
                        upd_valid <= 1'b0;
                    end else begin
                        init_idx <= init_idx + 9'd1;
                        upd_ip   <= (AMSB+1)'(init_idx + 9'd1);
                    end
                end
`endif
            end else if (flush_eff) begin
                upd_valid <= 1'b0;
            end else if (pop) begin
                upd_valid          <= 1'b1;
                {upd_takb, upd_ip} <= mem[head];
            end else if (upd_valid && upd_ready) begin
                upd_valid <= 1'b0;
            end
        end
    end
endmodule
